forwarding_unit: RTL and testbench
==================================

// Module: forwarding_unit
// PURPOSE
//  Generates the Execute-stage operand forwarding selects (fw_sel_e) for operand A/B and the load-use stall.
//  Tracks rd/reg_write/mem_read of the in-flight instructions in EX, MEM and WB internally, in its own shadow pipeline.
//  Forwarding decisions are made while an instruction is in ID, then registered on the ID->EX advance,
//  so fw_a_sel_o/fw_b_sel_o are flop outputs aligned with the instruction currently in EX.
// PARAMETERS
//  REG_ADDR_WIDTH  5   register index width (x0..x31)
//  CNT_WIDTH       32  width of the saturating stall-event counter
// PORTS
//  clk             in   1               rising-edge clock
//  rst             in   1               synchronous, active-high reset
//  id_valid_i      in   1               ID holds a valid instruction
//  id_rs1_addr_i   in   REG_ADDR_WIDTH  rs1 of ID instruction
//  id_rs2_addr_i   in   REG_ADDR_WIDTH  rs2 of ID instruction
//  id_rs1_used_i   in   1               instruction reads rs1
//  id_rs2_used_i   in   1               instruction reads rs2
//  id_rd_addr_i    in   REG_ADDR_WIDTH  rd of ID instruction
//  id_reg_write_i  in   1               ID instruction writes rd
//  id_mem_read_i   in   1               ID instruction is a load
//  flush_i         in   1               taken branch/jump resolved in EX; kill the ID instruction
//  hold_i          in   1               global pipeline freeze (memory wait); all state holds
//  fw_a_sel_o      out  fw_sel_e        operand A select for EX (registered)
//  fw_b_sel_o      out  fw_sel_e        operand B select for EX (registered)
//  stall_o         out  1               load-use stall: freeze PC and IF/ID (combinational)
//  stall_cnt_o     out  CNT_WIDTH       number of load-use stall cycles, saturating
// BEHAVIOUR
//  Reset: all shadow valid bits 0, fw_a_sel_o=fw_b_sel_o=FW_NONE, stall_cnt_o=0.
//   stall_o is derived from the cleared state, so it is 0.
//  Shadow stages: EX{rd,wr,ld,v} -> MEM{rd,wr,v} -> WB{rd,wr,v}. Each stage shifts on every cycle with hold_i=0.
//  A stage counts as a producer only if v && wr && rd!=0. x0 is never forwarded.
//  Load-use: stall_o = id_valid_i && EX.v && EX.ld && EX.wr && EX.rd!=0 && match, where
//   match = (id_rs1_used_i && id_rs1_addr_i==EX.rd) || (id_rs2_used_i && id_rs2_addr_i==EX.rd).
//   stall_o is forced to 0 when flush_i=1.
//  Next selects, computed per operand from the ID fields:
//   - rs matches a producer in EX (will be in MEM) and that producer is not a load -> FW_MEM_ALU
//   - else rs matches a producer in MEM (will be in WB) -> FW_WB_DATA
//   - else FW_NONE
//   - EX match has priority over MEM match (youngest producer wins).
//   - An unused rs always gives FW_NONE.
//  Per-cycle update when hold_i=0:
//   - flush_i=1 or stall_o=1 or !id_valid_i: EX.v<=0 (bubble) and both selects <= FW_NONE.
//   - otherwise: EX <= ID fields (v=1) and selects <= computed values.
//   - MEM<=EX and WB<=MEM unconditionally, so a load advances under stall.
//   - The stalled consumer re-evaluates next cycle; the load is then in MEM, which gives FW_WB_DATA.
//  hold_i=1: every register holds, including selects and stall_cnt_o. stall_o remains combinational.
//  flush_i together with stall condition: flush wins; bubble inserted, stall_o=0, counter not incremented.
//  stall_cnt_o increments by 1 on each cycle with stall_o=1 && !hold_i; it saturates at all-ones.
//  Latency: 0-cycle stall_o. Selects are valid in the same cycle the instruction occupies EX.
// STRUCTURE
//  defines package: reuse fw_sel_e {FW_NONE, FW_MEM_ALU, FW_WB_DATA}; add REG_ADDR_WIDTH constant.
//   Add struct hz_stage_t {rd, wr, ld, v} for the shadow stages.
//  Sub-module fw_src_select (combinational): one rs + EX/MEM shadow -> fw_sel_e.
//   Instantiated twice (operands A and B).
// TESTING
//  1. add x5 then add x6,x5,x1 back-to-back -> in EX cycle fw_a_sel_o=FW_MEM_ALU, fw_b_sel_o=FW_NONE, stall_o=0.
//  2. add x5; nop; sub x7,x2,x5 -> fw_b_sel_o=FW_WB_DATA.
//     Then add x5 twice followed by use of x5 -> FW_MEM_ALU (youngest wins).
//  3. lw x8 followed by add x9,x8,x8 -> stall_o=1 for exactly 1 cycle, EX bubble,
//     then both selects FW_WB_DATA, stall_cnt_o=1.
//  4. addi x0,x0,1 then add x3,x0,x0 -> both selects FW_NONE, no stall.
//     Same sequence with rs1_used=0 -> FW_NONE.
//  5. lw x8 / use x8 with flush_i=1 in the stall cycle -> stall_o=0, bubble, counter unchanged.
//  6. hold_i=1 for 3 cycles mid-sequence -> selects/stall_cnt_o frozen, and forwarding resumes correctly.
//     rst asserted mid-stream -> next cycle selects FW_NONE, stall_o=0, stall_cnt_o=0.

Source files
------------

// File: rtl/forwarding_unit_pkg.sv
// rtl/forwarding_unit_pkg.sv - shared types for the EX-stage operand forwarding unit
package forwarding_unit_pkg;

  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    FW_NONE    = 2'd0,
    FW_MEM_ALU = 2'd1,
    FW_WB_DATA = 2'd2
  } fw_sel_e;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      wr;
    logic                      ld;
    logic                      v;
  } hz_stage_t;

  // x0 is hard-wired to zero, so it never counts as a producer.
  function automatic logic is_producer(input logic                      v,
                                       input logic                      wr,
                                       input logic [REG_ADDR_WIDTH-1:0] rd,
                                       input logic [REG_ADDR_WIDTH-1:0] rs);
    return v && wr && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/forwarding_unit_fw_src_select.sv
// rtl/forwarding_unit_fw_src_select.sv - per-operand forwarding source select
module fw_src_select
  import forwarding_unit_pkg::*;
(
  input  logic [REG_ADDR_WIDTH-1:0] rs_addr_i,
  input  logic                      rs_used_i,
  input  hz_stage_t                 ex_i,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd_i,
  input  logic                      mem_wr_i,
  input  logic                      mem_v_i,
  output fw_sel_e                   sel_o
);

  // Youngest producer wins; a load in EX has no ALU result to forward yet.
  always_comb begin
    sel_o = FW_NONE;
    if (rs_used_i) begin
      if (is_producer(ex_i.v, ex_i.wr, ex_i.rd, rs_addr_i) && !ex_i.ld) begin
        sel_o = FW_MEM_ALU;
      end else if (is_producer(mem_v_i, mem_wr_i, mem_rd_i, rs_addr_i)) begin
        sel_o = FW_WB_DATA;
      end
    end
  end

endmodule

// File: rtl/forwarding_unit.sv
// rtl/forwarding_unit.sv - EX operand forwarding selects and load-use stall
module forwarding_unit
  import forwarding_unit_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
  input  logic                      id_rs1_used_i,
  input  logic                      id_rs2_used_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr_i,
  input  logic                      id_reg_write_i,
  input  logic                      id_mem_read_i,
  input  logic                      flush_i,
  input  logic                      hold_i,
  output fw_sel_e                   fw_a_sel_o,
  output fw_sel_e                   fw_b_sel_o,
  output logic                      stall_o,
  output logic [CNT_WIDTH-1:0]      stall_cnt_o
);

  // WB-stage data is picked up while the producer sits in MEM at ID time,
  // so the shadow pipeline only needs EX and MEM entries.
  hz_stage_t                 ex_q, ex_d;
  logic [REG_ADDR_WIDTH-1:0] mem_rd_q;
  logic                      mem_wr_q;
  logic                      mem_v_q;
  fw_sel_e                   fw_a_q, fw_a_d, fw_b_q, fw_b_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

  fw_sel_e sel_a;
  fw_sel_e sel_b;
  logic    ex_load_hit;
  logic    rs_match;
  logic    bubble;

  fw_src_select u_sel_a (
    .rs_addr_i (id_rs1_addr_i),
    .rs_used_i (id_rs1_used_i),
    .ex_i      (ex_q),
    .mem_rd_i  (mem_rd_q),
    .mem_wr_i  (mem_wr_q),
    .mem_v_i   (mem_v_q),
    .sel_o     (sel_a)
  );

  fw_src_select u_sel_b (
    .rs_addr_i (id_rs2_addr_i),
    .rs_used_i (id_rs2_used_i),
    .ex_i      (ex_q),
    .mem_rd_i  (mem_rd_q),
    .mem_wr_i  (mem_wr_q),
    .mem_v_i   (mem_v_q),
    .sel_o     (sel_b)
  );

  assign ex_load_hit = ex_q.v && ex_q.ld && ex_q.wr && (ex_q.rd != '0);
  assign rs_match    = (id_rs1_used_i && (id_rs1_addr_i == ex_q.rd)) ||
                       (id_rs2_used_i && (id_rs2_addr_i == ex_q.rd));
  assign stall_o     = id_valid_i && ex_load_hit && rs_match && !flush_i;
  assign bubble      = flush_i || stall_o || !id_valid_i;

  always_comb begin
    ex_d   = '0;
    fw_a_d = FW_NONE;
    fw_b_d = FW_NONE;
    cnt_d  = cnt_q;
    if (!bubble) begin
      ex_d   = '{rd: id_rd_addr_i, wr: id_reg_write_i, ld: id_mem_read_i, v: 1'b1};
      fw_a_d = sel_a;
      fw_b_d = sel_b;
    end
    if (stall_o && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q     <= '0;
      mem_rd_q <= '0;
      mem_wr_q <= 1'b0;
      mem_v_q  <= 1'b0;
      fw_a_q   <= FW_NONE;
      fw_b_q   <= FW_NONE;
      cnt_q    <= '0;
    end else if (!hold_i) begin
      ex_q     <= ex_d;
      mem_rd_q <= ex_q.rd;
      mem_wr_q <= ex_q.wr;
      mem_v_q  <= ex_q.v;
      fw_a_q   <= fw_a_d;
      fw_b_q   <= fw_b_d;
      cnt_q    <= cnt_d;
    end
  end

  assign fw_a_sel_o  = fw_a_q;
  assign fw_b_sel_o  = fw_b_q;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_forwarding_unit.sv
// tb/tb_forwarding_unit.sv - directed self-checking bench for forwarding_unit
module tb_forwarding_unit;
  import forwarding_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
  logic        id_rs1_used_i, id_rs2_used_i;
  logic        id_reg_write_i, id_mem_read_i;
  logic        flush_i, hold_i;
  fw_sel_e     fw_a_sel_o, fw_b_sel_o;
  logic        stall_o;
  logic [31:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  forwarding_unit #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid_i     (id_valid_i),
    .id_rs1_addr_i  (id_rs1_addr_i),
    .id_rs2_addr_i  (id_rs2_addr_i),
    .id_rs1_used_i  (id_rs1_used_i),
    .id_rs2_used_i  (id_rs2_used_i),
    .id_rd_addr_i   (id_rd_addr_i),
    .id_reg_write_i (id_reg_write_i),
    .id_mem_read_i  (id_mem_read_i),
    .flush_i        (flush_i),
    .hold_i         (hold_i),
    .fw_a_sel_o     (fw_a_sel_o),
    .fw_b_sel_o     (fw_b_sel_o),
    .stall_o        (stall_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic wr, input logic ld);
    id_valid_i = v; id_rs1_addr_i = rs1; id_rs1_used_i = u1;
    id_rs2_addr_i = rs2; id_rs2_used_i = u2; id_rd_addr_i = rd;
    id_reg_write_i = wr; id_mem_read_i = ld;
    #1;
  endtask

  task automatic nop();
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; flush_i = 1'b0; hold_i = 1'b0;
    nop();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (fw_a_sel_o !== FW_NONE) begin errors++; $display("FAIL reset_fw_a got %0d want %0d", fw_a_sel_o, FW_NONE); end
    checks++; if (fw_b_sel_o !== FW_NONE) begin errors++; $display("FAIL reset_fw_b got %0d want %0d", fw_b_sel_o, FW_NONE); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stall_o); end
    checks++; if (stall_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", stall_cnt_o); end
  endtask

  task automatic test_alu_fwd();
    do_reset();
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5,x1,x2
    tick();
    issue(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);   // add x6,x5,x1
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL alu_stall got %0b want 0", stall_o); end
    tick();
    nop();
    checks++; if (fw_a_sel_o !== FW_MEM_ALU) begin errors++; $display("FAIL alu_fw_a got %0d want %0d", fw_a_sel_o, FW_MEM_ALU); end
    checks++; if (fw_b_sel_o !== FW_NONE) begin errors++; $display("FAIL alu_fw_b got %0d want %0d", fw_b_sel_o, FW_NONE); end
  endtask

  task automatic test_wb_fwd();
    do_reset();
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5
    tick();
    nop();
    tick();
    issue(1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0);   // sub x7,x2,x5
    tick();
    checks++; if (fw_b_sel_o !== FW_WB_DATA) begin errors++; $display("FAIL wb_fw_b got %0d want %0d", fw_b_sel_o, FW_WB_DATA); end
    checks++; if (fw_a_sel_o !== FW_NONE) begin errors++; $display("FAIL wb_fw_a got %0d want %0d", fw_a_sel_o, FW_NONE); end
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5
    tick();
    issue(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5 again
    tick();
    issue(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);   // use x5
    tick();
    nop();
    checks++; if (fw_a_sel_o !== FW_MEM_ALU) begin errors++; $display("FAIL youngest_fw_a got %0d want %0d", fw_a_sel_o, FW_MEM_ALU); end
  endtask

  task automatic test_load_use();
    do_reset();
    issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);   // lw x8
    tick();
    issue(1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);   // add x9,x8,x8
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b want 1", stall_o); end
    tick();
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL lu_stall_once got %0b want 0", stall_o); end
    checks++; if (fw_a_sel_o !== FW_NONE) begin errors++; $display("FAIL lu_bubble_a got %0d want %0d", fw_a_sel_o, FW_NONE); end
    checks++; if (stall_cnt_o !== 32'd1) begin errors++; $display("FAIL lu_cnt got %0d want 1", stall_cnt_o); end
    tick();
    nop();
    checks++; if (fw_a_sel_o !== FW_WB_DATA) begin errors++; $display("FAIL lu_fw_a got %0d want %0d", fw_a_sel_o, FW_WB_DATA); end
    checks++; if (fw_b_sel_o !== FW_WB_DATA) begin errors++; $display("FAIL lu_fw_b got %0d want %0d", fw_b_sel_o, FW_WB_DATA); end
    checks++; if (stall_cnt_o !== 32'd1) begin errors++; $display("FAIL lu_cnt_hold got %0d want 1", stall_cnt_o); end
  endtask

  task automatic test_x0_unused();
    do_reset();
    issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);   // addi x0,x0,1
    tick();
    issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0);   // add x3,x0,x0
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL x0_stall got %0b want 0", stall_o); end
    tick();
    checks++; if (fw_a_sel_o !== FW_NONE) begin errors++; $display("FAIL x0_fw_a got %0d want %0d", fw_a_sel_o, FW_NONE); end
    checks++; if (fw_b_sel_o !== FW_NONE) begin errors++; $display("FAIL x0_fw_b got %0d want %0d", fw_b_sel_o, FW_NONE); end
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5
    tick();
    issue(1'b1, 5'd5, 1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);   // rs1 unused, rs2 = x5
    tick();
    checks++; if (fw_a_sel_o !== FW_NONE) begin errors++; $display("FAIL unused_fw_a got %0d want %0d", fw_a_sel_o, FW_NONE); end
    checks++; if (fw_b_sel_o !== FW_MEM_ALU) begin errors++; $display("FAIL unused_fw_b got %0d want %0d", fw_b_sel_o, FW_MEM_ALU); end
    issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);   // lw x0
    tick();
    issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);   // use x0
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL ldx0_stall got %0b want 0", stall_o); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);   // lw x8
    tick();
    issue(1'b1, 5'd8, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
    flush_i = 1'b1;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_stall got %0b want 0", stall_o); end
    tick();
    flush_i = 1'b0;
    nop();
    checks++; if (fw_a_sel_o !== FW_NONE) begin errors++; $display("FAIL flush_fw_a got %0d want %0d", fw_a_sel_o, FW_NONE); end
    checks++; if (stall_cnt_o !== 32'd0) begin errors++; $display("FAIL flush_cnt got %0d want 0", stall_cnt_o); end
  endtask

  task automatic test_hold_and_reset();
    do_reset();
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5
    tick();
    issue(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);   // lw x8,0(x5)
    tick();
    issue(1'b1, 5'd8, 1'b1, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0);   // add x9,x8,x3
    hold_i = 1'b1;
    #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL hold_stall got %0b want 1", stall_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (fw_a_sel_o !== FW_MEM_ALU) begin errors++; $display("FAIL hold_fw_a[%0d] got %0d want %0d", i, fw_a_sel_o, FW_MEM_ALU); end
      checks++; if (stall_cnt_o !== 32'd0) begin errors++; $display("FAIL hold_cnt[%0d] got %0d want 0", i, stall_cnt_o); end
    end
    hold_i = 1'b0;
    tick();
    checks++; if (fw_a_sel_o !== FW_NONE) begin errors++; $display("FAIL hold_bubble got %0d want %0d", fw_a_sel_o, FW_NONE); end
    checks++; if (stall_cnt_o !== 32'd1) begin errors++; $display("FAIL hold_cnt_after got %0d want 1", stall_cnt_o); end
    tick();
    checks++; if (fw_a_sel_o !== FW_WB_DATA) begin errors++; $display("FAIL hold_resume_a got %0d want %0d", fw_a_sel_o, FW_WB_DATA); end
    checks++; if (fw_b_sel_o !== FW_NONE) begin errors++; $display("FAIL hold_resume_b got %0d want %0d", fw_b_sel_o, FW_NONE); end
    issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);   // lw x8
    tick();
    issue(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);   // stalled consumer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (fw_a_sel_o !== FW_NONE) begin errors++; $display("FAIL rst_fw_a got %0d want %0d", fw_a_sel_o, FW_NONE); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b want 0", stall_o); end
    checks++; if (stall_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_cnt got %0d want 0", stall_cnt_o); end
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; hold_i = 1'b0;
    nop();
    test_reset();
    test_alu_fwd();
    test_wb_fwd();
    test_load_use();
    test_x0_unused();
    test_flush();
    test_hold_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
